// File: rtl/video_types.sv
// Shared video-subsystem constants and types used by the OAM DMA sequencer.
package video_types;

    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam int          OAM_SIZE     = 160;
    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;

    localparam int PHASE_W = 8;
    typedef logic [PHASE_W-1:0] phase_t;

    typedef enum logic [1:0] {IDLE, REQ, XFER} dma_state_t;

endpackage

// File: rtl/oam_dma_controller_if.sv
// CPU register port, arbiter handshake and memory bus of the OAM DMA sequencer.
interface oam_dma_if;

    logic        cfg_we;
    logic [15:0] cfg_addr;
    logic [7:0]  cfg_wdata;
    logic [7:0]  cfg_rdata;
    logic        bus_req;
    logic        bus_gnt;
    logic [15:0] mem_addr;
    logic        mem_re;
    logic [7:0]  mem_rdata;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic        dma_active;
    logic        dma_done;

    modport master (
        input  cfg_we, cfg_addr, cfg_wdata, bus_gnt, mem_rdata,
        output cfg_rdata, bus_req, mem_addr, mem_re, mem_we, mem_wdata,
               dma_active, dma_done
    );

    modport slave (
        output cfg_we, cfg_addr, cfg_wdata, bus_gnt, mem_rdata,
        input  cfg_rdata, bus_req, mem_addr, mem_re, mem_we, mem_wdata,
               dma_active, dma_done
    );

endinterface

// File: rtl/dma_slot_timer.sv
// Per-byte phase counter; phases 0, 2 and padding stall while the grant is low.
module dma_slot_timer #(
    parameter int CYCLES_PER_BYTE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    input  logic gnt,
    output logic p0_en,
    output logic p1_en,
    output logic p2_en,
    output logic slot_end
);
    import video_types::*;

    localparam phase_t LAST = phase_t'(CYCLES_PER_BYTE - 1);

    phase_t phase_q;
    logic   advance;

    assign p0_en    = run && gnt && (phase_q == phase_t'(0));
    assign p1_en    = run && (phase_q == phase_t'(1));
    // Phase 1 only captures returning read data, so it never waits on the grant.
    assign p2_en    = run && gnt && (phase_q == phase_t'(2));
    assign advance  = run && (p1_en || gnt);
    assign slot_end = advance && (phase_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
        end else if (clr) begin
            phase_q <= '0;
        end else if (advance) begin
            phase_q <= slot_end ? '0 : phase_q + 1'b1;
        end
    end

endmodule

// File: rtl/oam_dma_controller.sv
// OAM DMA sequencer: copies XFER_LEN bytes from {page,00} into OAM, one byte per slot.
// Optional build macro OAM_DMA_ECHO_MAP_EN folds echo-RAM source pages (>=E0) down by 20h.
module oam_dma_controller #(
    parameter logic [15:0] DMA_REG_ADDR    = video_types::DMA_REG_ADDR,
    parameter logic [15:0] OAM_BASE        = video_types::OAM_BASE,
    parameter int          XFER_LEN        = video_types::OAM_SIZE,
    parameter int          CYCLES_PER_BYTE = 4
) (
    input logic        clk,
    input logic        rst_n,
    oam_dma_if.master  bus
);
    import video_types::*;

    dma_state_t state_q, state_d;
    logic       done_q, done_d;
    logic [7:0] src_page, idx_q, rd_latch, eff_page;
    logic       trigger, last_byte;
    logic       p0_en, p1_en, p2_en, slot_end;

    assign trigger   = bus.cfg_we && (bus.cfg_addr == DMA_REG_ADDR);
    assign last_byte = (idx_q == 8'(XFER_LEN - 1));

    dma_slot_timer #(.CYCLES_PER_BYTE(CYCLES_PER_BYTE)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (trigger),
        .run      (state_q == XFER),
        .gnt      (bus.bus_gnt),
        .p0_en    (p0_en),
        .p1_en    (p1_en),
        .p2_en    (p2_en),
        .slot_end (slot_end)
    );

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: ;
            REQ:  if (bus.bus_gnt) state_d = XFER;
            XFER: if (slot_end && last_byte) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // A register write restarts from any state and suppresses a coincident done.
        if (trigger) begin
            state_d = REQ;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            done_q   <= 1'b0;
            src_page <= 8'h00;
            idx_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (trigger) begin
                src_page <= bus.cfg_wdata;
                idx_q    <= 8'h00;
            end else if (slot_end) begin
                idx_q <= last_byte ? 8'h00 : idx_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (p1_en) rd_latch <= bus.mem_rdata;
    end

`ifdef OAM_DMA_ECHO_MAP_EN
    assign eff_page = (src_page >= 8'hE0) ? src_page - 8'h20 : src_page;
`else
    assign eff_page = src_page;
`endif

    assign bus.cfg_rdata  = (bus.cfg_addr == DMA_REG_ADDR) ? src_page : 8'h00;
    assign bus.bus_req    = (state_q != IDLE);
    assign bus.dma_active = (state_q != IDLE);
    assign bus.dma_done   = done_q;
    assign bus.mem_re     = p0_en;
    assign bus.mem_we     = p2_en;
    assign bus.mem_addr   = p0_en ? {eff_page, idx_q} :
                            p2_en ? OAM_BASE + {8'h00, idx_q} : 16'h0000;
    assign bus.mem_wdata  = p2_en ? rd_latch : 8'h00;

endmodule

// File: doc/oam_dma_controller.md
# oam_dma_controller

Sequencer for DMG-style OAM DMA: a CPU write to the DMA register starts a 160-byte copy from a source page (XX00–XX9F) into OAM (FE00–FE9F). The block sits beside the whizgraphics peripheral. It requests the shared memory bus from the system arbiter and paces one byte per slot. It reports activity so the CPU-side decoder can block OAM accesses while a copy runs.

## Interface
Parameters:
- DMA_REG_ADDR, 16'hFF46, register address that triggers DMA
- OAM_BASE, 16'hFE00, first destination address
- XFER_LEN, 160, bytes per transfer
- CYCLES_PER_BYTE, 4, clocks per byte slot (must be ≥3)

Ports:
- clk  in  1  system clock; all logic on its rising edge
- rst_n  in  1  reset; asynchronous, active-low
- cfg_we  in  1  CPU write strobe
- cfg_addr  in  16  CPU address
- cfg_wdata  in  8  CPU write data
- cfg_rdata  out  8  DMA register value when cfg_addr==DMA_REG_ADDR, else 8'h00 (combinational)
- bus_req  out  1  request for the shared memory bus
- bus_gnt  in  1  grant from the arbiter
- mem_addr  out  16  memory address
- mem_re  out  1  read strobe; data returns on mem_rdata one cycle later
- mem_rdata  in  8  read data
- mem_we  out  1  write strobe
- mem_wdata  out  8  write data
- dma_active  out  1  a transfer is in progress
- dma_done  out  1  one-cycle pulse at transfer completion

## Operation
- Trigger: a cycle with cfg_we=1 and cfg_addr==DMA_REG_ADDR loads src_page and resets idx=0 and phase=0. The FSM then enters REQ. The load happens in every state, so a write during a transfer restarts it with the new page.
- States:
  - IDLE: bus_req=0. Moves to REQ on trigger.
  - REQ: bus_req=1. Moves to XFER once bus_gnt=1.
  - XFER: bus_req=1. Runs byte slots.
  - Completion: after the last phase of byte XFER_LEN-1, the FSM returns to IDLE.
- Byte slot, with phase counter 0..CYCLES_PER_BYTE-1:
  - Phase 0: executes only when bus_gnt=1. Drives mem_re=1 and mem_addr={src_page,idx[7:0]}.
  - Phase 1: always follows phase 0 with no stall. Captures mem_rdata into the data latch. No strobe.
  - Phase 2: executes only when bus_gnt=1. Drives mem_we=1, mem_addr=OAM_BASE+idx, mem_wdata=latch.
  - Phases ≥3: idle padding.
- Grant withdrawal: phases 0, 2 and ≥3 hold while bus_gnt=0. While the grant is low, mem_re and mem_we are 0 and bus_req stays 1.
- Index update: idx increments after the final phase of each slot. idx is 8 bits; XFER_LEN ≤ 256.
- Outputs: mem_addr and mem_wdata are 0 when no strobe is asserted. dma_active=1 in REQ and XFER.
- Reset: rst_n low at any time aborts immediately. No done pulse is generated.

## Timing
- Reset values:
  - outputs: bus_req=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, dma_active=0, dma_done=0
  - internal: src_page=8'h00, so cfg_rdata reads 8'h00
- Start: trigger write in cycle T. REQ with bus_req=1 and dma_active=1 from T+1.
- First read: XFER is entered at T+2 if bus_gnt=1 at T+1, and the first mem_re occurs at T+2.
- Duration: with the grant held high, the transfer occupies XFER_LEN×CYCLES_PER_BYTE cycles in XFER (640 at defaults).
- Completion: in the cycle after the final slot, dma_done=1, dma_active=0 and bus_req=0 (state IDLE).
- Simultaneous events: a trigger in the same cycle as completion wins. No dma_done pulse; the FSM goes to REQ.

## Configuration
- OAM_DMA_ECHO_MAP_EN:
  - Defined: a source page ≥8'hE0 is read from page−8'h20, mirroring echo RAM onto work RAM. cfg_rdata still returns the written value.
  - Undefined: the source page is used unmodified.

## Structure
- Shared package video_types holds:
  - OAM_BASE, OAM_SIZE and DMA_REG_ADDR constants
  - typedef enum dma_state_t {IDLE, REQ, XFER}
  - typedef for the phase counter width
- One sub-module, dma_slot_timer: the phase counter with grant-stall logic. Outputs are phase-0 and phase-2 strobe enables plus a slot_end pulse.

## Test plan
- Basic copy: fill C100–C19F with random bytes, hold bus_gnt=1, write 8'hC1 to FF46 → FE00–FE9F match the source. dma_done pulses exactly 642 cycles after the write. cfg_rdata reads 8'hC1.
- Grant withdrawal: drop bus_gnt for 10 cycles after byte 50 → no strobes while low, no byte skipped or duplicated, completion delayed by exactly 10 cycles.
- Restart: write 8'hD0 after 40 bytes of a C1 transfer → no dma_done for the first run. FE00–FE9F end equal to D000–D09F.
- Reset mid-transfer: assert rst_n=0 at byte 80 → all outputs 0 within the same cycle. After release the FSM is IDLE and cfg_rdata=8'h00.
- Echo mapping: write 8'hE2 with OAM_DMA_ECHO_MAP_EN defined → reads target C200–C29F. Without the macro → reads target E200–E29F.
- Delayed grant: hold bus_gnt=0 for 20 cycles after the trigger → bus_req=1 and dma_active=1 with no strobes. The first mem_re occurs in the cycle after the grant is seen.
